// File: rtl/video_timing_pkg.sv
// Default frame timing constants, graphics mode encodings and the slow-mode
// predicate shared by the video timing generator.
package video_timing_pkg;

    localparam int H_TOTAL_DEF       = 228;
    localparam int H_SYNC_END_DEF    = 14;
    localparam int H_BLANK_END_DEF   = 34;
    localparam int H_BLANK_START_DEF = 225;
    localparam int H_ACT_START_DEF   = 64;
    localparam int H_ACT_END_DEF     = 192;
    localparam int PRELOAD_DEF       = 2;
    localparam int DA_HALF_DEF       = 4;

    localparam int V_TOTAL_PAL_DEF   = 312;
    localparam int V_TOTAL_NTSC_DEF  = 259;
    localparam int V_TOP_PAL_DEF     = 64;
    localparam int V_TOP_NTSC_DEF    = 48;
    localparam int V_ACTIVE_DEF      = 192;
    localparam int V_SYNC_DEF        = 4;
    localparam int V_BLANK_DEF       = 8;

    localparam int ROW_HEIGHT_DEF    = 12;
    localparam int SLOW_DIV_DEF      = 2;
    localparam int BLINK_FIELDS_DEF  = 16;

    typedef enum logic [2:0] {
        GM_CG1 = 3'b000,
        GM_RG1 = 3'b001,
        GM_CG2 = 3'b010,
        GM_RG2 = 3'b011,
        GM_CG3 = 3'b100,
        GM_RG3 = 3'b101,
        GM_CG6 = 3'b110,
        GM_RG6 = 3'b111
    } gmode_t;

    // Only the lowest-resolution graphics mode shifts at the reduced pixel rate.
    function automatic logic is_slow_mode(input logic ang, input logic [2:0] gmode);
        return ang && (gmode == GM_CG1);
    endfunction

endpackage

// File: rtl/video_ce_divider.sv
// Pixel clock-enable divider: high one cycle in SLOW_DIV, phase forced to 0
// by a synchronous clear so the line always starts on an enabled cycle.
module video_ce_divider
    import video_timing_pkg::*;
#(
    parameter int SLOW_DIV = SLOW_DIV_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic ce
);

    localparam int PH_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

    logic [PH_W-1:0] phase;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            phase <= '0;
        end else if (phase == PH_W'(SLOW_DIV - 1)) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign ce = (phase == '0);

endmodule

// File: rtl/video_timing_gen.sv
// Frame timing generator: column/line counters with frame-boundary mode
// shadowing, decoded into registered sync, blank, window and strobe outputs.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL       = H_TOTAL_DEF,
    parameter int H_SYNC_END    = H_SYNC_END_DEF,
    parameter int H_BLANK_END   = H_BLANK_END_DEF,
    parameter int H_BLANK_START = H_BLANK_START_DEF,
    parameter int H_ACT_START   = H_ACT_START_DEF,
    parameter int H_ACT_END     = H_ACT_END_DEF,
    parameter int PRELOAD       = PRELOAD_DEF,
    parameter int DA_HALF       = DA_HALF_DEF,
    parameter int V_TOTAL_PAL   = V_TOTAL_PAL_DEF,
    parameter int V_TOTAL_NTSC  = V_TOTAL_NTSC_DEF,
    parameter int V_TOP_PAL     = V_TOP_PAL_DEF,
    parameter int V_TOP_NTSC    = V_TOP_NTSC_DEF,
    parameter int V_ACTIVE      = V_ACTIVE_DEF,
    parameter int V_SYNC        = V_SYNC_DEF,
    parameter int V_BLANK       = V_BLANK_DEF,
    parameter int ROW_HEIGHT    = ROW_HEIGHT_DEF,
    parameter int SLOW_DIV      = SLOW_DIV_DEF,
    parameter int BLINK_FIELDS  = BLINK_FIELDS_DEF
) (
    input  logic       Clk,
    input  logic       Rstn,
    input  logic [2:0] GMode,
    input  logic       AnG,
    input  logic       FrameFormat,
    output logic       PixelCE,
    output logic       HSn,
    output logic       FSn,
    output logic       BackPorch,
    output logic       Active,
    output logic       Load,
    output logic       DA0,
    output logic [3:0] AlphaRow,
    output logic [7:0] LineAddr,
    output logic       FieldStart,
    output logic       Blink
);

    localparam int V_MAX    = (V_TOTAL_PAL > V_TOTAL_NTSC) ? V_TOTAL_PAL : V_TOTAL_NTSC;
    localparam int COL_W    = $clog2(H_TOTAL);
    localparam int LINE_W   = $clog2(V_MAX);
    localparam int FLD_W    = (BLINK_FIELDS > 1) ? $clog2(BLINK_FIELDS) : 1;
    localparam int DA_START = H_ACT_START - PRELOAD;

    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [FLD_W-1:0]  field_cnt;
    logic [3:0]        alpha_cnt;
    logic              blink_st;
    logic [2:0]        gmode_s;
    logic              ang_s;
    logic              fmt_s;

    int   c, l, v_total, v_top;
    logic line_wrap, frame_wrap, row_act, div_ce;
    logic ce_p0, hs_n_p0, fs_n_p0, bp_p0, act_p0, load_p0, da0_p0, fst_p0;
    logic [7:0] la_p0;

    video_ce_divider #(
        .SLOW_DIV(SLOW_DIV)
    ) u_ce_div (
        .clk  (Clk),
        .rstn (Rstn),
        .clear(line_wrap),
        .ce   (div_ce)
    );

    // p0: combinational decode of the current counter state
    always_comb begin
        c          = int'(col);
        l          = int'(line);
        v_total    = fmt_s ? V_TOTAL_PAL : V_TOTAL_NTSC;
        v_top      = fmt_s ? V_TOP_PAL : V_TOP_NTSC;
        line_wrap  = (c == H_TOTAL - 1);
        frame_wrap = line_wrap && (l == v_total - 1);
        row_act    = (l >= v_top) && (l < v_top + V_ACTIVE);
        act_p0     = row_act && (c >= H_ACT_START) && (c < H_ACT_END);
        ce_p0      = is_slow_mode(ang_s, gmode_s) ? div_ce : 1'b1;
        load_p0    = act_p0 && ce_p0 && ((c - H_ACT_START) % 4 == 0);
        da0_p0     = row_act && (c >= DA_START) && (c < H_ACT_END) &&
                     (((c - DA_START) / DA_HALF) % 2 == 1);
        hs_n_p0    = !(c < H_SYNC_END);
        fs_n_p0    = !(l < V_SYNC);
        bp_p0      = (c < H_BLANK_END) || (c >= H_BLANK_START) || (l < V_BLANK);
        la_p0      = row_act ? 8'(l - v_top) : 8'd0;
        fst_p0     = (c == 0) && (l == 0);
    end

    // p1: counters advance and decoded values land in the output registers
    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            col        <= '0;
            line       <= '0;
            field_cnt  <= '0;
            alpha_cnt  <= '0;
            blink_st   <= 1'b0;
            gmode_s    <= GMode;
            ang_s      <= AnG;
            fmt_s      <= FrameFormat;
            PixelCE    <= 1'b0;
            HSn        <= 1'b1;
            FSn        <= 1'b1;
            BackPorch  <= 1'b1;
            Active     <= 1'b0;
            Load       <= 1'b0;
            DA0        <= 1'b0;
            AlphaRow   <= '0;
            LineAddr   <= '0;
            FieldStart <= 1'b0;
            Blink      <= 1'b0;
        end else begin
            PixelCE    <= ce_p0;
            HSn        <= hs_n_p0;
            FSn        <= fs_n_p0;
            BackPorch  <= bp_p0;
            Active     <= act_p0;
            Load       <= load_p0;
            DA0        <= da0_p0;
            AlphaRow   <= alpha_cnt;
            LineAddr   <= la_p0;
            FieldStart <= fst_p0;
            Blink      <= blink_st;

            col <= line_wrap ? '0 : col + 1'b1;

            if (line_wrap) begin
                // Row counter restarts on entry to the window and holds outside it.
                if (l + 1 == v_top) begin
                    alpha_cnt <= '0;
                end else if (row_act) begin
                    alpha_cnt <= (alpha_cnt == 4'(ROW_HEIGHT - 1)) ? 4'd0 : alpha_cnt + 4'd1;
                end
            end

            if (frame_wrap) begin
                line    <= '0;
                gmode_s <= GMode;
                ang_s   <= AnG;
                fmt_s   <= FrameFormat;
                if (field_cnt == FLD_W'(BLINK_FIELDS - 1)) begin
                    field_cnt <= '0;
                    blink_st  <= !blink_st;
                end else begin
                    field_cnt <= field_cnt + 1'b1;
                end
            end else if (line_wrap) begin
                line <= line + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a scaled-down frame geometry.
module tb_video_timing_gen;

    localparam int H_T   = 40;
    localparam int HSE   = 3;
    localparam int HBE   = 6;
    localparam int HBS   = 38;
    localparam int HAS   = 12;
    localparam int HAE   = 32;
    localparam int PRE   = 2;
    localparam int DAH   = 4;
    localparam int VTP   = 30;
    localparam int VTN   = 26;
    localparam int VTOPP = 10;
    localparam int VTOPN = 8;
    localparam int VACT  = 12;
    localparam int VSYNC = 2;
    localparam int VBLNK = 4;
    localparam int RH    = 5;
    localparam int SDIV  = 2;
    localparam int BF    = 4;

    localparam int B_CE = 20, B_HS = 19, B_FS = 18, B_ACT = 16, B_DA = 14, B_FST = 1, B_BL = 0;
    localparam logic [20:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 4'd0, 8'd0, 1'b0, 1'b0};

    logic       Clk, Rstn, AnG, FrameFormat;
    logic [2:0] GMode;
    logic       PixelCE, HSn, FSn, BackPorch, Active, Load, DA0, FieldStart, Blink;
    logic [3:0] AlphaRow;
    logic [7:0] LineAddr;

    video_timing_gen #(
        .H_TOTAL(H_T), .H_SYNC_END(HSE), .H_BLANK_END(HBE), .H_BLANK_START(HBS),
        .H_ACT_START(HAS), .H_ACT_END(HAE), .PRELOAD(PRE), .DA_HALF(DAH),
        .V_TOTAL_PAL(VTP), .V_TOTAL_NTSC(VTN), .V_TOP_PAL(VTOPP), .V_TOP_NTSC(VTOPN),
        .V_ACTIVE(VACT), .V_SYNC(VSYNC), .V_BLANK(VBLNK), .ROW_HEIGHT(RH),
        .SLOW_DIV(SDIV), .BLINK_FIELDS(BF)
    ) dut (
        .Clk(Clk), .Rstn(Rstn), .GMode(GMode), .AnG(AnG), .FrameFormat(FrameFormat),
        .PixelCE(PixelCE), .HSn(HSn), .FSn(FSn), .BackPorch(BackPorch), .Active(Active),
        .Load(Load), .DA0(DA0), .AlphaRow(AlphaRow), .LineAddr(LineAddr),
        .FieldStart(FieldStart), .Blink(Blink)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total, bad, cyc;
    logic [20:0] obs;
    logic [20:0] exp_q[$];

    int m_col, m_line, m_field, m_alpha;
    logic m_blink, sh_ang, sh_fmt;
    logic [2:0] sh_gm;

    int last_fs, last_period, pos;
    int hs_low, fs_low, act_cnt, ce_cnt, first_act, last_act, first_da, last_da, a_wraps;
    int p_hs_low, p_fs_low, p_act, p_ce, p_first_act, p_last_act, p_first_da, p_last_da, p_wraps;
    logic [3:0] prev_alpha;

    function automatic logic [20:0] model_out();
        int vtop, la;
        logic row, act, ce, ld, da, hsn, fsn, bp, fst;
        vtop = sh_fmt ? VTOPP : VTOPN;
        row  = (m_line >= vtop) && (m_line < vtop + VACT);
        act  = row && (m_col >= HAS) && (m_col < HAE);
        ce   = (sh_ang && sh_gm == 3'b000) ? (m_col % SDIV == 0) : 1'b1;
        ld   = act && ce && ((m_col - HAS) % 4 == 0);
        da   = row && (m_col >= HAS - PRE) && (m_col < HAE) &&
               ((m_col - (HAS - PRE)) % (2 * DAH) >= DAH);
        hsn  = (m_col >= HSE);
        fsn  = (m_line >= VSYNC);
        bp   = (m_col < HBE) || (m_col >= HBS) || (m_line < VBLNK);
        la   = row ? m_line - vtop : 0;
        fst  = (m_col == 0) && (m_line == 0);
        return {ce, hsn, fsn, bp, act, ld, da, 4'(m_alpha), 8'(la), fst, m_blink};
    endfunction

    function automatic void model_adv();
        int vt, vtop, nl;
        logic row;
        if (!Rstn) begin
            m_col = 0; m_line = 0; m_field = 0; m_alpha = 0; m_blink = 1'b0;
            sh_gm = GMode; sh_ang = AnG; sh_fmt = FrameFormat;
            return;
        end
        if (m_col < H_T - 1) begin
            m_col++;
            return;
        end
        vt   = sh_fmt ? VTP : VTN;
        vtop = sh_fmt ? VTOPP : VTOPN;
        row  = (m_line >= vtop) && (m_line < vtop + VACT);
        m_col = 0;
        nl = (m_line == vt - 1) ? 0 : m_line + 1;
        if (nl == vtop) m_alpha = 0;
        else if (row) m_alpha = (m_alpha + 1) % RH;
        if (nl == 0) begin
            if (m_field == BF - 1) begin
                m_field = 0;
                m_blink = ~m_blink;
            end else begin
                m_field++;
            end
            sh_gm = GMode; sh_ang = AnG; sh_fmt = FrameFormat;
        end
        m_line = nl;
    endfunction

    // One clock: predict, let the DUT take the edge, compare, then gather frame statistics.
    task automatic tick();
        logic [20:0] e, got;
        e = Rstn ? model_out() : RST_VEC;
        exp_q.push_back(e);
        model_adv();
        @(posedge Clk);
        #1;
        got = {PixelCE, HSn, FSn, BackPorch, Active, Load, DA0, AlphaRow, LineAddr, FieldStart, Blink};
        obs = got;
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL scoreboard cyc=%0d got=%h expected=%h", cyc, got, e);
        end
        cyc++;
        if (got[B_FST]) begin
            last_period = cyc - last_fs;
            last_fs = cyc;
            p_hs_low = hs_low; p_fs_low = fs_low; p_act = act_cnt; p_ce = ce_cnt;
            p_first_act = first_act; p_last_act = last_act;
            p_first_da = first_da; p_last_da = last_da; p_wraps = a_wraps;
            hs_low = 0; fs_low = 0; act_cnt = 0; ce_cnt = 0; a_wraps = 0;
            first_act = -1; last_act = -1; first_da = -1; last_da = -1;
        end
        pos = cyc - last_fs;
        if (!got[B_HS]) hs_low++;
        if (!got[B_FS]) fs_low++;
        if (got[B_CE]) ce_cnt++;
        if (got[B_ACT]) begin
            act_cnt++;
            if (first_act < 0) first_act = pos;
            last_act = pos;
        end
        if (got[B_DA]) begin
            if (first_da < 0) first_da = pos;
            last_da = pos;
        end
        if (prev_alpha == 4'(RH - 1) && AlphaRow == 4'd0) a_wraps++;
        prev_alpha = AlphaRow;
        @(negedge Clk);
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (obs[B_FST]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rstn = 1'b0; FrameFormat = 1'b1; AnG = 1'b0; GMode = 3'b010;
        repeat (3) tick();
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL reset_values got=%h expected=%h", obs, RST_VEC);
        end
        Rstn = 1'b1;
    endtask

    task automatic test_pal_timing();
        bit ok1, ok2;
        wait_fs(ok1);
        wait_fs(ok2);
        total++;
        if (!(ok1 && ok2)) begin
            bad++;
            $display("FAIL pal_fs_timeout got=%0d%0d expected=11", ok1, ok2);
        end
        total++;
        if (last_period !== VTP * H_T) begin
            bad++;
            $display("FAIL pal_period got=%0d expected=%0d", last_period, VTP * H_T);
        end
        total++;
        if (p_hs_low !== HSE * VTP) begin
            bad++;
            $display("FAIL pal_hsync_low got=%0d expected=%0d", p_hs_low, HSE * VTP);
        end
        total++;
        if (p_fs_low !== VSYNC * H_T) begin
            bad++;
            $display("FAIL pal_fsync_low got=%0d expected=%0d", p_fs_low, VSYNC * H_T);
        end
        total++;
        if (p_act !== VACT * (HAE - HAS)) begin
            bad++;
            $display("FAIL pal_active_count got=%0d expected=%0d", p_act, VACT * (HAE - HAS));
        end
    endtask

    task automatic test_format_switch();
        bit ok;
        repeat (15 * H_T) tick();
        FrameFormat = 1'b0;
        wait_fs(ok);
        total++;
        if (last_period !== VTP * H_T) begin
            bad++;
            $display("FAIL switch_current_frame got=%0d expected=%0d", last_period, VTP * H_T);
        end
        wait_fs(ok);
        total++;
        if (last_period !== VTN * H_T) begin
            bad++;
            $display("FAIL ntsc_period got=%0d expected=%0d", last_period, VTN * H_T);
        end
        total++;
        if (p_first_act !== VTOPN * H_T + HAS) begin
            bad++;
            $display("FAIL ntsc_first_active got=%0d expected=%0d", p_first_act, VTOPN * H_T + HAS);
        end
        total++;
        if (p_last_act !== (VTOPN + VACT - 1) * H_T + HAE - 1) begin
            bad++;
            $display("FAIL ntsc_last_active got=%0d expected=%0d", p_last_act,
                     (VTOPN + VACT - 1) * H_T + HAE - 1);
        end
    endtask

    task automatic test_alpha_da();
        bit ok;
        wait_fs(ok);
        total++;
        if (p_first_da !== VTOPN * H_T + HAS - PRE + DAH) begin
            bad++;
            $display("FAIL da0_first_rise got=%0d expected=%0d", p_first_da, VTOPN * H_T + HAS - PRE + DAH);
        end
        total++;
        if (p_last_da !== (VTOPN + VACT - 1) * H_T + HAE - 1) begin
            bad++;
            $display("FAIL da0_last_high got=%0d expected=%0d", p_last_da, (VTOPN + VACT - 1) * H_T + HAE - 1);
        end
        total++;
        if (p_wraps !== VACT / RH) begin
            bad++;
            $display("FAIL alpha_row_wraps got=%0d expected=%0d", p_wraps, VACT / RH);
        end
    endtask

    task automatic test_slow_mode();
        bit ok;
        repeat (100) tick();
        AnG = 1'b1; GMode = 3'b000;
        wait_fs(ok);
        total++;
        if (p_ce !== VTN * H_T) begin
            bad++;
            $display("FAIL slow_deferred got=%0d expected=%0d", p_ce, VTN * H_T);
        end
        wait_fs(ok);
        total++;
        if (p_ce !== VTN * H_T / SDIV) begin
            bad++;
            $display("FAIL slow_ce_count got=%0d expected=%0d", p_ce, VTN * H_T / SDIV);
        end
        repeat (100) tick();
        GMode = 3'b101;
        wait_fs(ok);
        total++;
        if (p_ce !== VTN * H_T / SDIV) begin
            bad++;
            $display("FAIL fast_deferred got=%0d expected=%0d", p_ce, VTN * H_T / SDIV);
        end
        wait_fs(ok);
        total++;
        if (p_ce !== VTN * H_T) begin
            bad++;
            $display("FAIL fast_ce_count got=%0d expected=%0d", p_ce, VTN * H_T);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (m_line == VTOPN + 2 && m_col == HAS + 3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mid_reset_position got=0 expected=1");
        end
        Rstn = 1'b0;
        tick();
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL mid_reset_values got=%h expected=%h", obs, RST_VEC);
        end
        Rstn = 1'b1;
        tick();
        total++;
        if ({obs[B_FST], obs[B_HS], obs[B_FS]} !== 3'b100) begin
            bad++;
            $display("FAIL restart_line0 got=%b expected=100", {obs[B_FST], obs[B_HS], obs[B_FS]});
        end
    endtask

    task automatic test_blink();
        bit ok;
        repeat (BF - 1) wait_fs(ok);
        total++;
        if (obs[B_BL] !== 1'b0) begin
            bad++;
            $display("FAIL blink_before_toggle got=%b expected=0", obs[B_BL]);
        end
        wait_fs(ok);
        total++;
        if (obs[B_BL] !== 1'b1) begin
            bad++;
            $display("FAIL blink_toggle got=%b expected=1", obs[B_BL]);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; last_fs = 0; last_period = 0; pos = 0;
        hs_low = 0; fs_low = 0; act_cnt = 0; ce_cnt = 0; a_wraps = 0;
        first_act = -1; last_act = -1; first_da = -1; last_da = -1;
        p_hs_low = 0; p_fs_low = 0; p_act = 0; p_ce = 0; p_wraps = 0;
        p_first_act = -1; p_last_act = -1; p_first_da = -1; p_last_da = -1;
        prev_alpha = 4'd0;
        m_col = 0; m_line = 0; m_field = 0; m_alpha = 0; m_blink = 1'b0;
        sh_gm = 3'b000; sh_ang = 1'b0; sh_fmt = 1'b1;
        Rstn = 1'b0; AnG = 1'b0; GMode = 3'b010; FrameFormat = 1'b1;
        test_reset();
        test_pal_timing();
        test_format_switch();
        test_alpha_da();
        test_slow_mode();
        test_mid_reset();
        test_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
